// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a command-stream RAM.
// Each transaction is an address command, a data command and, for reads, a bounded wait for RAM data.
module ram_arbiter #(
   parameter int ADDR_SIZE = 8,
   parameter int TIMEOUT   = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             req,
   input  logic [1:0]             we,
   input  logic [ADDR_SIZE-1:0]   addr0,
   input  logic [ADDR_SIZE-1:0]   addr1,
   input  logic [ADDR_SIZE-1:0]   wdata0,
   input  logic [ADDR_SIZE-1:0]   wdata1,
   output logic [1:0]             ack,
   output logic [ADDR_SIZE-1:0]   rdata,
   output logic                   rd_err,
   output logic                   ram_rx_valid,
   output logic [ADDR_SIZE+1:0]   ram_din,
   input  logic                   ram_tx_valid,
   input  logic [ADDR_SIZE-1:0]   ram_dout
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, CMD1, CMD2, WAIT, DONE} state_t;

   state_t                 state, state_nx;
   logic                   ptr, ptr_nx;
   logic                   id, id_nx;
   logic                   grant;
   logic                   we_l, we_nx;
   logic [ADDR_SIZE-1:0]   addr_l, addr_nx;
   logic [ADDR_SIZE-1:0]   wdata_l, wdata_nx;
   logic [CW-1:0]          cnt, cnt_nx;
   logic [1:0]             ack_nx;
   logic [ADDR_SIZE-1:0]   rdata_nx;
   logic                   rd_err_nx;
   logic                   rx_valid_nx;
   logic [ADDR_SIZE+1:0]   din_nx;

   // Outputs are computed for the state being entered, so they appear
   // registered during that state.
   always_comb begin
      state_nx    = state;
      ptr_nx      = ptr;
      id_nx       = id;
      grant       = 1'b0;
      we_nx       = we_l;
      addr_nx     = addr_l;
      wdata_nx    = wdata_l;
      cnt_nx      = cnt;
      ack_nx      = 2'b00;
      rdata_nx    = rdata;
      rd_err_nx   = rd_err;
      rx_valid_nx = 1'b0;
      din_nx      = '0;
      case (state)
         IDLE: begin
            if (req != 2'b00) begin
               grant       = (req == 2'b11) ? ptr : req[1];
               id_nx       = grant;
               we_nx       = we[grant];
               addr_nx     = grant ? addr1 : addr0;
               wdata_nx    = grant ? wdata1 : wdata0;
               cnt_nx      = '0;
               state_nx    = CMD1;
               rx_valid_nx = 1'b1;
               din_nx      = {(we_nx ? 2'b00 : 2'b10), addr_nx};
            end
         end
         CMD1: begin
            state_nx    = CMD2;
            rx_valid_nx = 1'b1;
            din_nx      = we_l ? {2'b01, wdata_l} : {2'b11, {ADDR_SIZE{1'b0}}};
         end
         CMD2: begin
            if (we_l) begin
               state_nx   = DONE;
               ack_nx[id] = 1'b1;
               rdata_nx   = '0;
               rd_err_nx  = 1'b0;
               ptr_nx     = ~id;
            end else begin
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (ram_tx_valid) begin
               state_nx   = DONE;
               ack_nx[id] = 1'b1;
               rdata_nx   = ram_dout;
               rd_err_nx  = 1'b0;
               ptr_nx     = ~id;
            end else begin
               // Counter stops at TIMEOUT because the state is left on that cycle.
               cnt_nx = cnt + 1'b1;
               if (cnt == CW'(TIMEOUT - 1)) begin
                  state_nx   = DONE;
                  ack_nx[id] = 1'b1;
                  rdata_nx   = '0;
                  rd_err_nx  = 1'b1;
                  ptr_nx     = ~id;
               end
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         ptr          <= 1'b0;
         id           <= 1'b0;
         we_l         <= 1'b0;
         addr_l       <= '0;
         wdata_l      <= '0;
         cnt          <= '0;
         ack          <= 2'b00;
         rdata        <= '0;
         rd_err       <= 1'b0;
         ram_rx_valid <= 1'b0;
         ram_din      <= '0;
      end else begin
         state        <= state_nx;
         ptr          <= ptr_nx;
         id           <= id_nx;
         we_l         <= we_nx;
         addr_l       <= addr_nx;
         wdata_l      <= wdata_nx;
         cnt          <= cnt_nx;
         ack          <= ack_nx;
         rdata        <= rdata_nx;
         rd_err       <= rd_err_nx;
         ram_rx_valid <= rx_valid_nx;
         ram_din      <= din_nx;
      end
   end

endmodule
